// File: rtl/toycpu_data_bus_slave_if.sv
// CPU data-side bus plus byte TX stream between the core harness and
// the data bus slave.
interface toycpu_data_bus_slave_if;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_wdata,
    input  mem_rdata,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_we,
    input  mem_wdata,
    output mem_rdata,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );
endinterface

// File: rtl/toycpu_data_bus_slave.sv
// Data-side responder: word RAM, GPIO, tick counter and TX byte FIFO
// behind a single-cycle load/store bus.
module toycpu_data_bus_slave #(
  parameter int ADDR_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  toycpu_data_bus_slave_if.slave      bus,
  output logic [15:0]                 gpio_out,
  output logic                        irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = PW + 1;
  localparam int WORDS = 1 << ADDR_BITS;
  localparam logic [16:0] RAM_TOP = 17'(WORDS);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [LW-1:0] LONE = LW'(1);
  localparam logic [LW-1:0] LFULL = LW'(FIFO_DEPTH);

  localparam logic [15:0] A_GPIO = 16'hFF00;
  localparam logic [15:0] A_TXD  = 16'hFF01;
  localparam logic [15:0] A_STAT = 16'hFF02;
  localparam logic [15:0] A_TICK = 16'hFF03;

  logic [15:0] ram [WORDS];
  logic [7:0]  fifo [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level;
  logic          ovf;
  logic [15:0]   tick;

  logic is_ram, is_gpio, is_txd, is_stat, is_tick;
  logic empty, full, pop, push_req, push, drop, clr;
  logic [15:0] status;

  assign is_ram  = {1'b0, bus.mem_addr} < RAM_TOP;
  assign is_gpio = bus.mem_addr == A_GPIO;
  assign is_txd  = bus.mem_addr == A_TXD;
  assign is_stat = bus.mem_addr == A_STAT;
  assign is_tick = bus.mem_addr == A_TICK;

  assign empty    = level == '0;
  assign full     = level == LFULL;
  assign pop      = !empty && bus.tx_ready;
  assign push_req = bus.mem_we && is_txd;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign clr      = bus.mem_we && is_stat && bus.mem_wdata[2];

  assign status = {8'h00, 4'(level), 1'b0, ovf, full, empty};

  assign bus.tx_valid = !empty;
  assign bus.tx_data  = fifo[rd_ptr];
  assign irq          = ovf;

  always_comb begin
    bus.mem_rdata = 16'h0000;
    unique case (1'b1)
      is_ram:  bus.mem_rdata = ram[bus.mem_addr[ADDR_BITS-1:0]];
      is_gpio: bus.mem_rdata = gpio_out;
      is_stat: bus.mem_rdata = status;
      is_tick: bus.mem_rdata = tick;
      default: bus.mem_rdata = 16'h0000;
    endcase
  end

  // Storage arrays carry no reset; rst only blocks the store.
  always_ff @(posedge clk) begin
    if (!rst && bus.mem_we && is_ram)
      ram[bus.mem_addr[ADDR_BITS-1:0]] <= bus.mem_wdata;
    if (!rst && push)
      fifo[wr_ptr] <= bus.mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out <= 16'h0000;
      tick     <= 16'h0000;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
    end else begin
      if (bus.mem_we && is_gpio)
        gpio_out <= bus.mem_wdata;
      if (bus.mem_we && is_tick)
        tick <= bus.mem_wdata;
      else
        tick <= tick + 16'h0001;
      if (push)
        wr_ptr <= wr_ptr + PONE;
      if (pop)
        rd_ptr <= rd_ptr + PONE;
      if (push && !pop)
        level <= level + LONE;
      else if (pop && !push)
        level <= level - LONE;
      // A dropped byte outranks a same-cycle clear.
      if (drop)
        ovf <= 1'b1;
      else if (clr)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_toycpu_data_bus_slave.sv
// Directed self-checking bench for toycpu_data_bus_slave.
module tb_toycpu_data_bus_slave;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] gpio_out;
  logic irq;
  int n_chk = 0;
  int n_fail = 0;

  toycpu_data_bus_slave_if bus ();

  toycpu_data_bus_slave #(
    .ADDR_BITS  (8),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic tick_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_we    = 1'b1;
    tick_cyc();
    bus.mem_we    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    bus.mem_addr = a;
    #1;
    d = bus.mem_rdata;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b1;
    bus.mem_we = 1'b0;
    bus.mem_addr = 16'h0000;
    bus.mem_wdata = 16'h0000;
    bus.tx_ready = 1'b0;
    tick_cyc();
    tick_cyc();
    rst = 1'b0;
    rd(16'hFF03, v);
    n_chk++;
    if (v !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_tick got %h want 0000", v);
    end
    rd(16'hFF02, v);
    n_chk++;
    if (v !== 16'h0001) begin
      n_fail++;
      $display("FAIL reset_status got %h want 0001", v);
    end
    n_chk++;
    if (gpio_out !== 16'h0000 || bus.tx_valid !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outs gpio %h txv %b irq %b want 0000 0 0",
               gpio_out, bus.tx_valid, irq);
    end
  endtask

  task automatic test_ram();
    logic [15:0] v;
    wr(16'h0080, 16'h1234);
    wr(16'h00FF, 16'hBEEF);
    rd(16'h0080, v);
    n_chk++;
    if (v !== 16'h1234) begin
      n_fail++;
      $display("FAIL ram_0080 got %h want 1234", v);
    end
    rd(16'h00FF, v);
    n_chk++;
    if (v !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL ram_00ff got %h want beef", v);
    end
    wr(16'h0100, 16'h5555);
    rd(16'h0100, v);
    n_chk++;
    if (v !== 16'h0000) begin
      n_fail++;
      $display("FAIL unmapped_0100 got %h want 0000", v);
    end
    rd(16'h0000, v);
    n_chk++;
    if (v === 16'h5555) begin
      n_fail++;
      $display("FAIL alias_0000 got %h want not 5555", v);
    end
    rd(16'hFF01, v);
    n_chk++;
    if (v !== 16'h0000) begin
      n_fail++;
      $display("FAIL txdata_read got %h want 0000", v);
    end
  endtask

  task automatic test_gpio_reset();
    logic [15:0] v;
    wr(16'hFF00, 16'hA5A5);
    n_chk++;
    if (gpio_out !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL gpio_write got %h want a5a5", gpio_out);
    end
    rd(16'hFF00, v);
    n_chk++;
    if (v !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL gpio_read got %h want a5a5", v);
    end
    rst = 1'b1;
    wr(16'hFF00, 16'h1111);
    rst = 1'b1;
    wr(16'h0080, 16'h9999);
    rst = 1'b0;
    n_chk++;
    if (gpio_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL gpio_after_rst got %h want 0000", gpio_out);
    end
    rd(16'h0080, v);
    n_chk++;
    if (v !== 16'h1234) begin
      n_fail++;
      $display("FAIL ram_kept_rst got %h want 1234", v);
    end
  endtask

  task automatic test_fifo_fill();
    logic [15:0] v;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      wr(16'hFF01, 16'h0041 + 16'(i));
    rd(16'hFF02, v);
    n_chk++;
    if (v !== 16'h0082) begin
      n_fail++;
      $display("FAIL fill_status got %h want 0082", v);
    end
    wr(16'hFF01, 16'h0049);
    rd(16'hFF02, v);
    n_chk++;
    if (v !== 16'h0086 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_status got %h irq %b want 0086 1", v, irq);
    end
    n_chk++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h41) begin
      n_fail++;
      $display("FAIL head got %b %h want 1 41", bus.tx_valid, bus.tx_data);
    end
    wr(16'hFF02, 16'h0004);
    rd(16'hFF02, v);
    n_chk++;
    if (v !== 16'h0082 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear got %h irq %b want 0082 0", v, irq);
    end
  endtask

  task automatic test_drain();
    logic [15:0] v;
    logic [7:0] held;
    logic stalled;
    int idx;
    idx = 0;
    stalled = 1'b0;
    held = 8'h00;
    for (int c = 0; c < 40; c++) begin
      bus.tx_ready = c[0];
      #1;
      if (bus.tx_valid !== 1'b1) break;
      if (stalled) begin
        n_chk++;
        if (bus.tx_data !== held) begin
          n_fail++;
          $display("FAIL drain_stable got %h want %h", bus.tx_data, held);
        end
      end
      n_chk++;
      if (bus.tx_data !== 8'h41 + 8'(idx)) begin
        n_fail++;
        $display("FAIL drain_order got %h want %h", bus.tx_data, 8'h41 + 8'(idx));
      end
      stalled = !bus.tx_ready;
      held = bus.tx_data;
      if (bus.tx_ready) idx++;
      tick_cyc();
    end
    bus.tx_ready = 1'b0;
    n_chk++;
    if (idx != 8) begin
      n_fail++;
      $display("FAIL drain_count got %0d want 8", idx);
    end
    rd(16'hFF02, v);
    n_chk++;
    if (v !== 16'h0001) begin
      n_fail++;
      $display("FAIL drain_status got %h want 0001", v);
    end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] v;
    logic [7:0] last;
    int cnt;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      wr(16'hFF01, 16'h0061 + 16'(i));
    bus.tx_ready = 1'b1;
    wr(16'hFF01, 16'h005A);
    bus.tx_ready = 1'b0;
    rd(16'hFF02, v);
    n_chk++;
    if (v !== 16'h0082 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL pushpop_status got %h irq %b want 0082 0", v, irq);
    end
    cnt = 0;
    last = 8'h00;
    bus.tx_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.tx_valid !== 1'b1) break;
      n_chk++;
      if (cnt < 7 && bus.tx_data !== 8'h62 + 8'(cnt)) begin
        n_fail++;
        $display("FAIL pushpop_order got %h want %h", bus.tx_data, 8'h62 + 8'(cnt));
      end
      last = bus.tx_data;
      cnt++;
      tick_cyc();
    end
    bus.tx_ready = 1'b0;
    n_chk++;
    if (cnt != 8 || last !== 8'h5A) begin
      n_fail++;
      $display("FAIL pushpop_last got %0d/%h want 8/5a", cnt, last);
    end
  endtask

  task automatic test_no_bypass();
    bus.tx_ready = 1'b1;
    bus.mem_addr = 16'hFF01;
    bus.mem_wdata = 16'h0077;
    bus.mem_we = 1'b1;
    #1;
    n_chk++;
    if (bus.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_valid got %b want 0", bus.tx_valid);
    end
    tick_cyc();
    bus.mem_we = 1'b0;
    n_chk++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h77) begin
      n_fail++;
      $display("FAIL bypass_next got %b %h want 1 77", bus.tx_valid, bus.tx_data);
    end
    tick_cyc();
    bus.tx_ready = 1'b0;
    n_chk++;
    if (bus.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_pop got %b want 0", bus.tx_valid);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [15:0] v;
    wr(16'hFF01, 16'h0011);
    wr(16'hFF01, 16'h0022);
    bus.tx_ready = 1'b1;
    rst = 1'b1;
    tick_cyc();
    rst = 1'b0;
    bus.tx_ready = 1'b0;
    rd(16'hFF02, v);
    n_chk++;
    if (bus.tx_valid !== 1'b0 || v !== 16'h0001) begin
      n_fail++;
      $display("FAIL rst_drain got %b %h want 0 0001", bus.tx_valid, v);
    end
  endtask

  task automatic test_tick();
    logic [15:0] a, b;
    rd(16'hFF03, a);
    tick_cyc();
    rd(16'hFF03, b);
    n_chk++;
    if (b !== a + 16'h0001) begin
      n_fail++;
      $display("FAIL tick_step got %h want %h", b, a + 16'h0001);
    end
    wr(16'hFF03, 16'hFFFE);
    rd(16'hFF03, a);
    n_chk++;
    if (a !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL tick_load got %h want fffe", a);
    end
    tick_cyc();
    rd(16'hFF03, a);
    n_chk++;
    if (a !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL tick_ffff got %h want ffff", a);
    end
    tick_cyc();
    rd(16'hFF03, a);
    n_chk++;
    if (a !== 16'h0000) begin
      n_fail++;
      $display("FAIL tick_wrap got %h want 0000", a);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_ram();
    test_gpio_reset();
    test_fifo_fill();
    test_drain();
    test_full_push_pop();
    test_no_bypass();
    test_reset_mid_drain();
    test_tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
